// File: rtl/vx_itr_router_if.sv
// Signal bundle for vx_itr_router: request side, mask writes and per-target delivery.
// master = producers/sockets, slave = router.
interface vx_itr_router_if #(
    parameter int NUM_SOURCES = 4,
    parameter int NUM_TARGETS = 2,
    parameter int VEC_WIDTH   = 8,
    parameter int SRC_W       = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
    parameter int TGT_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
);
    // Requests transfer on any cycle with src_valid & src_ready (ready never looks at valid).
    // Offers hold tgt_itr_valid with stable vector/src until ack or timeout; done ends the handler.
    logic [NUM_SOURCES-1:0]             src_valid;
    logic [NUM_SOURCES*VEC_WIDTH-1:0]   src_vector;
    logic [NUM_SOURCES*NUM_TARGETS-1:0] src_target;
    logic [NUM_SOURCES-1:0]             src_ready;
    logic                               mask_wr_valid;
    logic [TGT_W-1:0]                   mask_wr_target;
    logic [NUM_SOURCES-1:0]             mask_wr_data;
    logic [NUM_TARGETS-1:0]             tgt_itr_valid;
    logic [NUM_TARGETS*VEC_WIDTH-1:0]   tgt_itr_vector;
    logic [NUM_TARGETS*SRC_W-1:0]       tgt_itr_src;
    logic [NUM_TARGETS-1:0]             tgt_itr_ack;
    logic [NUM_TARGETS-1:0]             tgt_itr_done;
    logic [NUM_TARGETS*NUM_SOURCES-1:0] pending;
    logic [NUM_TARGETS-1:0]             timeout_err;
    logic                               busy;
    logic [2*NUM_TARGETS-1:0]           tgt_state;

    modport master (
        output src_valid, src_vector, src_target, mask_wr_valid, mask_wr_target, mask_wr_data,
        output tgt_itr_ack, tgt_itr_done,
        input  src_ready, tgt_itr_valid, tgt_itr_vector, tgt_itr_src, pending, timeout_err,
        input  busy, tgt_state
    );

    modport slave (
        input  src_valid, src_vector, src_target, mask_wr_valid, mask_wr_target, mask_wr_data,
        input  tgt_itr_ack, tgt_itr_done,
        output src_ready, tgt_itr_valid, tgt_itr_vector, tgt_itr_src, pending, timeout_err,
        output busy, tgt_state
    );
endinterface

// File: rtl/vx_itr_router.sv
// Multi-source, multi-target interrupt router: per-(target,source) pending bits, per-target
// masking, round-robin selection and an offer/ack/done delivery FSM with ack timeout.
module vx_itr_router #(
    parameter int NUM_SOURCES = 4,
    parameter int NUM_TARGETS = 2,
    parameter int VEC_WIDTH   = 8,
    parameter int ACK_TIMEOUT = 256,
    parameter int SRC_W       = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
    parameter int TGT_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input logic            clk,
    input logic            reset,
    vx_itr_router_if.slave bus
);
    localparam int NS    = NUM_SOURCES;
    localparam int NT    = NUM_TARGETS;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OFFER = 2'd1, ST_ACTIVE = 2'd2} state_e;

    state_e               state_q   [NT];
    state_e               state_d   [NT];
    logic [NS-1:0]        pend_q    [NT];
    logic [NS-1:0]        pend_d    [NT];
    logic [NS-1:0]        mask_q    [NT];
    logic [VEC_WIDTH-1:0] vec_q     [NT][NS];
    logic [SRC_W-1:0]     rr_q      [NT];
    logic [SRC_W-1:0]     rr_d      [NT];
    logic [SRC_W-1:0]     off_src_q [NT];
    logic [SRC_W-1:0]     off_src_d [NT];
    logic [VEC_WIDTH-1:0] off_vec_q [NT];
    logic [VEC_WIDTH-1:0] off_vec_d [NT];
    logic [TMR_W-1:0]     tmr_q     [NT];
    logic [TMR_W-1:0]     tmr_d     [NT];
    logic [NT-1:0]        terr_q, terr_d;
    logic [NS-1:0]        ready, accept;
    logic                 pick_vld  [NT];
    logic [SRC_W-1:0]     pick_src  [NT];
    logic [NT-1:0]        tgt_busy;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] s);
        return (int'(s) == NS - 1) ? '0 : s + 1'b1;
    endfunction

    // A source may re-issue only once none of the targets it now addresses still hold it.
    always_comb begin
        ready = '1;
        for (int s = 0; s < NS; s++)
            for (int t = 0; t < NT; t++)
                if (pend_q[t][s] && bus.src_target[s*NT+t]) ready[s] = 1'b0;
        accept = bus.src_valid & ready;
    end

    // Round-robin pick: first eligible source at or after rr, wrapping.
    always_comb begin : pick_blk
        int idx;
        idx = 0;
        for (int t = 0; t < NT; t++) begin
            pick_vld[t] = 1'b0;
            pick_src[t] = '0;
            for (int i = 0; i < NS; i++) begin
                idx = int'(rr_q[t]) + i;
                if (idx >= NS) idx = idx - NS;
                if (!pick_vld[t] && pend_q[t][idx] && mask_q[t][idx]) begin
                    pick_vld[t] = 1'b1;
                    pick_src[t] = SRC_W'(idx);
                end
            end
        end
    end

    always_comb begin
        terr_d = terr_q;
        for (int t = 0; t < NT; t++) begin
            state_d[t]   = state_q[t];
            pend_d[t]    = pend_q[t];
            rr_d[t]      = rr_q[t];
            off_src_d[t] = off_src_q[t];
            off_vec_d[t] = off_vec_q[t];
            tmr_d[t]     = tmr_q[t];
            for (int s = 0; s < NS; s++)
                if (accept[s] && bus.src_target[s*NT+t]) pend_d[t][s] = 1'b1;
            case (state_q[t])
                ST_IDLE: begin
                    if (pick_vld[t]) begin
                        state_d[t]   = ST_OFFER;
                        off_src_d[t] = pick_src[t];
                        off_vec_d[t] = vec_q[t][pick_src[t]];
                        tmr_d[t]     = '0;
                    end
                end
                ST_OFFER: begin
                    if (bus.tgt_itr_ack[t]) begin
                        pend_d[t][off_src_q[t]] = 1'b0;
                        rr_d[t]    = wrap_inc(off_src_q[t]);
                        state_d[t] = ST_ACTIVE;
                    end else if (tmr_q[t] == TMR_W'(ACK_TIMEOUT - 1)) begin
                        // Unacked offer is abandoned but stays pending; rr moves past it.
                        state_d[t] = ST_IDLE;
                        terr_d[t]  = 1'b1;
                        rr_d[t]    = wrap_inc(off_src_q[t]);
                    end else begin
                        tmr_d[t] = tmr_q[t] + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.tgt_itr_done[t]) state_d[t] = ST_IDLE;
                end
                default: state_d[t] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NT; t++) begin
                state_q[t]   <= ST_IDLE;
                pend_q[t]    <= '0;
                mask_q[t]    <= '1;
                rr_q[t]      <= '0;
                off_src_q[t] <= '0;
                off_vec_q[t] <= '0;
                tmr_q[t]     <= '0;
                for (int s = 0; s < NS; s++) vec_q[t][s] <= '0;
            end
            terr_q <= '0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                state_q[t]   <= state_d[t];
                pend_q[t]    <= pend_d[t];
                rr_q[t]      <= rr_d[t];
                off_src_q[t] <= off_src_d[t];
                off_vec_q[t] <= off_vec_d[t];
                tmr_q[t]     <= tmr_d[t];
                for (int s = 0; s < NS; s++)
                    if (accept[s] && bus.src_target[s*NT+t])
                        vec_q[t][s] <= bus.src_vector[s*VEC_WIDTH +: VEC_WIDTH];
                if (bus.mask_wr_valid && int'(bus.mask_wr_target) == t)
                    mask_q[t] <= bus.mask_wr_data;
            end
            terr_q <= terr_d;
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_out
        assign bus.tgt_itr_valid[t]                      = (state_q[t] == ST_OFFER);
        assign bus.tgt_itr_vector[t*VEC_WIDTH +: VEC_WIDTH] = off_vec_q[t];
        assign bus.tgt_itr_src[t*SRC_W +: SRC_W]         = off_src_q[t];
        assign bus.pending[t*NS +: NS]                   = pend_q[t];
        assign bus.tgt_state[2*t +: 2]                   = state_q[t];
        assign tgt_busy[t]                               = (state_q[t] != ST_IDLE) || (|pend_q[t]);
    end

    assign bus.src_ready   = ready;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = |tgt_busy;
endmodule

// File: tb/tb_vx_itr_router.sv
// Bench for vx_itr_router: directed scenarios plus a randomized run against a
// transaction-level model of pending sets, masks and round-robin delivery.
module tb_vx_itr_router;
    localparam int NS = 4;
    localparam int NT = 2;
    localparam int VW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    vx_itr_router_if #(.NUM_SOURCES(NS), .NUM_TARGETS(NT), .VEC_WIDTH(VW)) bus ();

    vx_itr_router #(.NUM_SOURCES(NS), .NUM_TARGETS(NT), .VEC_WIDTH(VW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.src_valid      = '0;
        bus.src_vector     = '0;
        bus.src_target     = '0;
        bus.mask_wr_valid  = 1'b0;
        bus.mask_wr_target = '0;
        bus.mask_wr_data   = '0;
        bus.tgt_itr_ack    = '0;
        bus.tgt_itr_done   = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int s, input logic [VW-1:0] v, input logic [NT-1:0] tg);
        bus.src_valid[s]              = 1'b1;
        bus.src_vector[s*VW +: VW]    = v;
        bus.src_target[s*NT +: NT]    = tg;
    endtask

    function automatic logic [VW-1:0] ovec(input int t);
        return bus.tgt_itr_vector[t*VW +: VW];
    endfunction

    function automatic logic [1:0] osrc(input int t);
        return bus.tgt_itr_src[t*2 +: 2];
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        bus.src_target = '1;
        #1;
        n_vec++; if (bus.src_ready !== 4'hF) begin n_err++; $display("FAIL reset_ready: got %h exp f", bus.src_ready); end
        n_vec++; if (bus.pending !== 8'h00) begin n_err++; $display("FAIL reset_pending: got %h exp 00", bus.pending); end
        n_vec++; if (bus.tgt_itr_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b exp 00", bus.tgt_itr_valid); end
        n_vec++; if (bus.timeout_err !== 2'b00) begin n_err++; $display("FAIL reset_terr: got %b exp 00", bus.timeout_err); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        n_vec++; if ({bus.tgt_itr_vector, bus.tgt_itr_src} !== '0) begin n_err++; $display("FAIL reset_offer_regs: got %h/%h exp 0", bus.tgt_itr_vector, bus.tgt_itr_src); end
        bus.src_target = '0;
    endtask

    task automatic test_single();
        apply_reset();
        set_req(0, 8'h2A, 2'b01);
        #1;
        n_vec++; if (bus.src_ready[0] !== 1'b1) begin n_err++; $display("FAIL single_ready_pre: got %b exp 1", bus.src_ready[0]); end
        tick();
        bus.src_valid = '0;
        n_vec++; if (bus.src_ready[0] !== 1'b0 || bus.pending[0] !== 1'b1) begin n_err++; $display("FAIL single_accept: ready %b pend %b exp 0/1", bus.src_ready[0], bus.pending[0]); end
        n_vec++; if (bus.tgt_itr_valid[0] !== 1'b0) begin n_err++; $display("FAIL single_early_offer: got %b exp 0", bus.tgt_itr_valid[0]); end
        tick();
        n_vec++; if (bus.tgt_itr_valid !== 2'b01 || ovec(0) !== 8'h2A || osrc(0) !== 2'd0) begin n_err++; $display("FAIL single_offer: valid %b vec %h src %0d exp 01/2a/0", bus.tgt_itr_valid, ovec(0), osrc(0)); end
        bus.tgt_itr_ack[0] = 1'b1;
        tick();
        bus.tgt_itr_ack = '0;
        n_vec++; if (bus.pending[0] !== 1'b0 || bus.src_ready[0] !== 1'b1 || bus.tgt_itr_valid[0] !== 1'b0) begin n_err++; $display("FAIL single_ack: pend %b ready %b valid %b exp 0/1/0", bus.pending[0], bus.src_ready[0], bus.tgt_itr_valid[0]); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_active: got %b exp 1", bus.busy); end
        bus.tgt_itr_done[0] = 1'b1;
        tick();
        bus.tgt_itr_done = '0;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done: got %b exp 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [VW-1:0] exp_vec [3];
        int            exp_src [3];
        apply_reset();
        set_req(1, 8'h11, 2'b01);
        set_req(2, 8'h12, 2'b01);
        set_req(3, 8'h13, 2'b01);
        tick();
        bus.src_valid = '0;
        tick();
        exp_src = '{1, 2, 3};
        exp_vec = '{8'h11, 8'h12, 8'h21};
        exp_vec[2] = 8'h13;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (bus.tgt_itr_valid[0] !== 1'b1 || osrc(0) !== 2'(exp_src[k]) || ovec(0) !== exp_vec[k]) begin n_err++; $display("FAIL rr_offer%0d: valid %b src %0d vec %h exp 1/%0d/%h", k, bus.tgt_itr_valid[0], osrc(0), ovec(0), exp_src[k], exp_vec[k]); end
            bus.tgt_itr_ack[0] = 1'b1;
            tick();
            bus.tgt_itr_ack = '0;
            // raise src1 again while src2 is in its handler: rr must still favour src3
            if (k == 1) begin
                set_req(1, 8'h21, 2'b01);
                tick();
                bus.src_valid = '0;
            end
            bus.tgt_itr_done[0] = 1'b1;
            tick();
            bus.tgt_itr_done = '0;
            tick();
        end
        n_vec++; if (bus.tgt_itr_valid[0] !== 1'b1 || osrc(0) !== 2'd1 || ovec(0) !== 8'h21) begin n_err++; $display("FAIL rr_late_src1: valid %b src %0d vec %h exp 1/1/21", bus.tgt_itr_valid[0], osrc(0), ovec(0)); end
        bus.tgt_itr_ack[0] = 1'b1;
        tick();
        bus.tgt_itr_ack = '0;
        bus.tgt_itr_done[0] = 1'b1;
        tick();
        bus.tgt_itr_done = '0;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rr_busy_end: got %b exp 0", bus.busy); end
    endtask

    task automatic test_multicast();
        apply_reset();
        set_req(2, 8'h55, 2'b11);
        tick();
        bus.src_valid = '0;
        n_vec++; if (bus.src_ready[2] !== 1'b0) begin n_err++; $display("FAIL mc_ready_drop: got %b exp 0", bus.src_ready[2]); end
        tick();
        n_vec++; if (bus.tgt_itr_valid !== 2'b11 || ovec(0) !== 8'h55 || ovec(1) !== 8'h55 || osrc(0) !== 2'd2 || osrc(1) !== 2'd2) begin n_err++; $display("FAIL mc_offer: valid %b vec %h/%h src %0d/%0d exp 11/55/55/2/2", bus.tgt_itr_valid, ovec(0), ovec(1), osrc(0), osrc(1)); end
        bus.tgt_itr_ack[0] = 1'b1;
        tick();
        bus.tgt_itr_ack = '0;
        n_vec++; if (bus.pending !== 8'h40 || bus.src_ready[2] !== 1'b0 || bus.tgt_itr_valid !== 2'b10) begin n_err++; $display("FAIL mc_half_ack: pend %h ready %b valid %b exp 40/0/10", bus.pending, bus.src_ready[2], bus.tgt_itr_valid); end
        bus.tgt_itr_ack[1] = 1'b1;
        tick();
        bus.tgt_itr_ack = '0;
        n_vec++; if (bus.pending !== 8'h00 || bus.src_ready[2] !== 1'b1) begin n_err++; $display("FAIL mc_full_ack: pend %h ready %b exp 00/1", bus.pending, bus.src_ready[2]); end
        bus.tgt_itr_done = 2'b11;
        tick();
        bus.tgt_itr_done = '0;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mc_busy_end: got %b exp 0", bus.busy); end
    endtask

    task automatic test_mask();
        apply_reset();
        bus.mask_wr_valid  = 1'b1;
        bus.mask_wr_target = 1'b1;
        bus.mask_wr_data   = 4'b1110;
        tick();
        bus.mask_wr_valid = 1'b0;
        set_req(0, 8'h33, 2'b10);
        tick();
        bus.src_valid = '0;
        tick();
        tick();
        n_vec++; if (bus.pending[4] !== 1'b1 || bus.tgt_itr_valid !== 2'b00) begin n_err++; $display("FAIL mask_blocked: pend %b valid %b exp 1/00", bus.pending[4], bus.tgt_itr_valid); end
        bus.mask_wr_valid = 1'b1;
        bus.mask_wr_data  = 4'hF;
        tick();
        bus.mask_wr_valid = 1'b0;
        n_vec++; if (bus.tgt_itr_valid[1] !== 1'b0) begin n_err++; $display("FAIL mask_latency: got %b exp 0", bus.tgt_itr_valid[1]); end
        tick();
        n_vec++; if (bus.tgt_itr_valid[1] !== 1'b1 || osrc(1) !== 2'd0 || ovec(1) !== 8'h33) begin n_err++; $display("FAIL mask_release: valid %b src %0d vec %h exp 1/0/33", bus.tgt_itr_valid[1], osrc(1), ovec(1)); end
        bus.tgt_itr_ack[1] = 1'b1;
        tick();
        bus.tgt_itr_ack = '0;
        bus.tgt_itr_done[1] = 1'b1;
        tick();
        bus.tgt_itr_done = '0;
    endtask

    task automatic test_timeout();
        int run;
        apply_reset();
        set_req(0, 8'h44, 2'b01);
        tick();
        bus.src_valid = '0;
        tick();
        n_vec++; if (bus.tgt_itr_valid[0] !== 1'b1 || bus.timeout_err[0] !== 1'b0) begin n_err++; $display("FAIL to_first_offer: valid %b terr %b exp 1/0", bus.tgt_itr_valid[0], bus.timeout_err[0]); end
        run = 0;
        for (int i = 0; i < TO + 4; i++) begin
            if (bus.tgt_itr_valid[0] !== 1'b1) break;
            run++;
            tick();
        end
        n_vec++; if (run != TO) begin n_err++; $display("FAIL to_valid_len: got %0d exp %0d", run, TO); end
        n_vec++; if (bus.timeout_err[0] !== 1'b1 || bus.pending[0] !== 1'b1) begin n_err++; $display("FAIL to_flag: terr %b pend %b exp 1/1", bus.timeout_err[0], bus.pending[0]); end
        tick();
        n_vec++; if (bus.tgt_itr_valid[0] !== 1'b1 || osrc(0) !== 2'd0) begin n_err++; $display("FAIL to_reoffer_same: valid %b src %0d exp 1/0", bus.tgt_itr_valid[0], osrc(0)); end
        set_req(1, 8'h45, 2'b01);
        tick();
        bus.src_valid = '0;
        repeat (TO - 1) tick();
        n_vec++; if (bus.tgt_itr_valid[0] !== 1'b0) begin n_err++; $display("FAIL to_second_expiry: got %b exp 0", bus.tgt_itr_valid[0]); end
        tick();
        n_vec++; if (bus.tgt_itr_valid[0] !== 1'b1 || osrc(0) !== 2'd1 || ovec(0) !== 8'h45) begin n_err++; $display("FAIL to_next_src: valid %b src %0d vec %h exp 1/1/45", bus.tgt_itr_valid[0], osrc(0), ovec(0)); end
        bus.tgt_itr_ack[0] = 1'b1;
        tick();
        bus.tgt_itr_ack = '0;
        bus.tgt_itr_done[0] = 1'b1;
        tick();
        bus.tgt_itr_done = '0;
        n_vec++; if (bus.timeout_err[0] !== 1'b1 || bus.pending[1] !== 1'b0) begin n_err++; $display("FAIL to_sticky: terr %b pend1 %b exp 1/0", bus.timeout_err[0], bus.pending[1]); end
    endtask

    task automatic test_reset_mid_active();
        apply_reset();
        for (int s = 0; s < NS; s++) set_req(s, VW'(8'h60 + s), 2'b01);
        tick();
        bus.src_valid = '0;
        tick();
        bus.tgt_itr_ack[0] = 1'b1;
        tick();
        bus.tgt_itr_ack = '0;
        n_vec++; if (bus.pending[3:0] !== 4'b1110 || bus.busy !== 1'b1) begin n_err++; $display("FAIL rma_setup: pend %b busy %b exp 1110/1", bus.pending[3:0], bus.busy); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (bus.pending !== 8'h00 || bus.tgt_itr_valid !== 2'b00 || bus.busy !== 1'b0 || bus.timeout_err !== 2'b00) begin n_err++; $display("FAIL rma_async: pend %h valid %b busy %b terr %b exp 0", bus.pending, bus.tgt_itr_valid, bus.busy, bus.timeout_err); end
        n_vec++; if (bus.src_ready !== 4'hF || bus.tgt_itr_vector !== '0 || bus.tgt_itr_src !== '0) begin n_err++; $display("FAIL rma_ready: ready %h vec %h src %h exp f/0/0", bus.src_ready, bus.tgt_itr_vector, bus.tgt_itr_src); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [NS-1:0]    m_pend [NT];
        logic [VW-1:0]    m_vec  [NT][NS];
        logic [NS-1:0]    m_mask [NT];
        int               m_rr   [NT];
        int               m_src  [NT];
        int               m_age  [NT];
        bit               m_off  [NT];
        bit               m_hnd  [NT];
        logic [VW-1:0]    m_ovec [NT];
        logic [NT-1:0]    m_terr;
        logic [NS-1:0]    exp_ready;
        logic [NT*NS-1:0] exp_pend;
        logic             exp_busy;
        int               cand;
        apply_reset();
        m_terr = '0;
        for (int t = 0; t < NT; t++) begin
            m_pend[t] = '0; m_mask[t] = '1; m_rr[t] = 0; m_src[t] = 0; m_age[t] = 0;
            m_off[t] = 1'b0; m_hnd[t] = 1'b0; m_ovec[t] = '0;
            for (int s = 0; s < NS; s++) m_vec[t][s] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int s = 0; s < NS; s++) begin
                bus.src_valid[s]           = ($urandom_range(0, 2) == 0);
                bus.src_vector[s*VW +: VW] = VW'($urandom);
                bus.src_target[s*NT +: NT] = NT'($urandom_range(0, 3));
            end
            bus.mask_wr_valid  = ($urandom_range(0, 19) == 0);
            bus.mask_wr_target = 1'($urandom_range(0, 1));
            bus.mask_wr_data   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            for (int t = 0; t < NT; t++) begin
                bus.tgt_itr_ack[t]  = ($urandom_range(0, 2) == 0);
                bus.tgt_itr_done[t] = ($urandom_range(0, 2) == 0);
            end
            #1;
            exp_ready = '1;
            exp_busy  = 1'b0;
            for (int t = 0; t < NT; t++) begin
                exp_pend[t*NS +: NS] = m_pend[t];
                if (|m_pend[t] || m_off[t] || m_hnd[t]) exp_busy = 1'b1;
                for (int s = 0; s < NS; s++)
                    if (m_pend[t][s] && bus.src_target[s*NT+t]) exp_ready[s] = 1'b0;
            end
            n_vec++; if (bus.src_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, bus.src_ready, exp_ready); end
            n_vec++; if (bus.pending !== exp_pend) begin n_err++; $display("FAIL rnd_pending c%0d: got %h exp %h", cyc, bus.pending, exp_pend); end
            n_vec++; if (bus.timeout_err !== m_terr) begin n_err++; $display("FAIL rnd_terr c%0d: got %b exp %b", cyc, bus.timeout_err, m_terr); end
            n_vec++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy c%0d: got %b exp %b", cyc, bus.busy, exp_busy); end
            for (int t = 0; t < NT; t++) begin
                n_vec++; if (bus.tgt_itr_valid[t] !== m_off[t]) begin n_err++; $display("FAIL rnd_valid c%0d t%0d: got %b exp %b", cyc, t, bus.tgt_itr_valid[t], m_off[t]); end
                if (m_off[t]) begin
                    n_vec++; if (osrc(t) !== 2'(m_src[t]) || ovec(t) !== m_ovec[t]) begin n_err++; $display("FAIL rnd_offer c%0d t%0d: src %0d vec %h exp %0d/%h", cyc, t, osrc(t), ovec(t), m_src[t], m_ovec[t]); end
                end
            end
            // model: advance one clock edge
            for (int t = 0; t < NT; t++) begin
                if (m_off[t]) begin
                    if (bus.tgt_itr_ack[t]) begin
                        m_pend[t][m_src[t]] = 1'b0;
                        m_rr[t]  = (m_src[t] + 1) % NS;
                        m_off[t] = 1'b0;
                        m_hnd[t] = 1'b1;
                    end else if (m_age[t] == TO - 1) begin
                        m_off[t]  = 1'b0;
                        m_terr[t] = 1'b1;
                        m_rr[t]   = (m_src[t] + 1) % NS;
                    end else begin
                        m_age[t]++;
                    end
                end else if (m_hnd[t]) begin
                    if (bus.tgt_itr_done[t]) m_hnd[t] = 1'b0;
                end else begin
                    for (int k = 0; k < NS; k++) begin
                        cand = (m_rr[t] + k) % NS;
                        if (m_pend[t][cand] && m_mask[t][cand]) begin
                            m_off[t]  = 1'b1;
                            m_src[t]  = cand;
                            m_ovec[t] = m_vec[t][cand];
                            m_age[t]  = 0;
                            break;
                        end
                    end
                end
            end
            for (int s = 0; s < NS; s++)
                if (bus.src_valid[s] && exp_ready[s])
                    for (int t = 0; t < NT; t++)
                        if (bus.src_target[s*NT+t]) begin
                            m_pend[t][s] = 1'b1;
                            m_vec[t][s]  = bus.src_vector[s*VW +: VW];
                        end
            if (bus.mask_wr_valid) m_mask[int'(bus.mask_wr_target)] = bus.mask_wr_data;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_multicast();
        test_mask();
        test_timeout();
        test_random();
        test_reset_mid_active();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
